pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that generalises the fixed-field stage registers (D/E/M/W) into one reusable block with a valid/ready handshake.
- Packs any stage payload into a DATA_W vector. Provides stall backpressure through a 2-entry skid buffer with registered in_ready, so throughput stays at one transfer per clock.
- Adds a synchronous flush that inserts a bubble, plus transfer and stall performance counters.
- Sits between any two pipeline stages. Hazard control drives flush and out_ready.

Parameters:
- DATA_W, 32+32+32+5+4, packed payload width (default covers PC, instr, ALUOut, WriteReg, control bits); must be >= 1.
- CLEAR_ON_FLUSH, 1, 1 = zero the data registers on flush/reset; 0 = leave data unchanged, only valid bits cleared.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous bubble insert; kills all held and incoming entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  registered; stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a valid entry.
- out_ready  in  1  downstream accepts (0 = stall).
- out_data  out  DATA_W  payload of the oldest entry (main register).
- cnt_xfer  out  CNT_W  count of output transfers (out_valid & out_ready); wraps modulo 2^CNT_W.
- cnt_stall  out  CNT_W  cycles with out_valid & !out_ready; saturates at all-ones.

Behaviour:
- Storage is a main register (main_v, main_d) feeding out_valid/out_data, plus a skid register (skid_v, skid_d).
- State encoding: EMPTY (no entries), ONE (main only), TWO (main and skid).
- Derived signals:
  - in_ready = (state != TWO), driven from a flop.
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- Transitions (no flush):
  - EMPTY: acc -> ONE, main_d <= in_data.
  - ONE:
    - acc & drn -> ONE, main_d <= in_data.
    - acc & !drn -> TWO, skid_d <= in_data.
    - !acc & drn -> EMPTY.
    - else hold.
  - TWO: in_ready = 0, so acc is impossible.
    - drn -> ONE, main_d <= skid_d.
    - else hold; main and skid data stay stable.
- Ordering: entries leave in arrival order; skid data never overtakes main.
- Latency: 1 cycle from acc to out_valid when empty. Sustained throughput 1/clk with out_ready held high.
- Stall: out_data and out_valid hold while out_ready = 0. At most one extra entry is absorbed after in_ready drops.
- Flush:
  - Next state = EMPTY; main_v, skid_v and in_ready's next value become 0, 0, 1 respectively.
  - A same-cycle incoming entry is dropped.
  - A same-cycle drn is still counted in cnt_xfer, because downstream consumed it.
  - If CLEAR_ON_FLUSH = 1, main_d and skid_d <= 0.
- Reset:
  - Has priority over flush and handshake.
  - Values after reset: state EMPTY, out_valid 0, in_ready 1, out_data 0, skid data 0, cnt_xfer 0, cnt_stall 0.
  - Reset asserted mid-stall discards both entries.
- Counters:
  - cnt_xfer increments on drn and wraps.
  - cnt_stall increments on out_valid & !out_ready and holds at 2^CNT_W-1.
  - Counters are not cleared by flush.
- No X propagation: data registers are written only on the transitions listed above.

Decomposition:
- Shared package pipe_pkg:
  - state encodings ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2.
  - default DATA_W constant.
  - field offset constants for packing PC/Instr/ALUOut/WriteReg/control into in_data.
- One natural sub-module: pipe_perf_cnt, which holds the two counters (wrap vs saturate selected per instance). The handshake and skid logic stays in pipe_stage_reg.

Test Plan:
- Reset then idle: reset = 1 for 2 clk -> out_valid = 0, in_ready = 1, out_data = 0, both counters 0.
- Streaming: out_ready = 1, send 0x11, 0x22, 0x33 on consecutive clocks -> same values appear on out_data one clock later each; cnt_xfer = 3; in_ready stays 1.
- Stall and skid:
  - Send 0xA1 with out_ready = 0; send 0xA2 next cycle -> state TWO, in_ready = 0, out_data = 0xA1 held.
  - Raise out_ready -> 0xA1 then 0xA2 leave in order; cnt_stall = number of stalled valid cycles.
- Flush in TWO:
  - Hold two entries, assert flush with in_valid = 1 carrying 0xFF -> next cycle out_valid = 0, in_ready = 1, out_data = 0 (CLEAR_ON_FLUSH = 1).
  - 0xFF never appears on the output.
- Reset priority: reset and flush and in_valid all asserted in state ONE -> all outputs at reset values; cnt_stall cleared.
- Counter limits:
  - CNT_W = 2: hold a stall for 5 cycles -> cnt_stall = 3.
  - Do 5 transfers -> cnt_xfer = 1 (wraps).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the reusable pipeline stage register: FSM encodings,
// the default payload width and the field layout of the packed stage payload.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int ALU_W   = 32;
    localparam int WREG_W  = 5;
    localparam int CTRL_W  = 4;

    localparam int DEFAULT_DATA_W = PC_W + INSTR_W + ALU_W + WREG_W + CTRL_W;

    // Payload packing, LSB first: control, WriteReg, ALUOut, Instr, PC.
    localparam int CTRL_LSB  = 0;
    localparam int WREG_LSB  = CTRL_LSB + CTRL_W;
    localparam int ALU_LSB   = WREG_LSB + WREG_W;
    localparam int INSTR_LSB = ALU_LSB + ALU_W;
    localparam int PC_LSB    = INSTR_LSB + INSTR_W;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Single performance counter; SATURATE selects hold-at-all-ones instead of
// wrapping modulo 2^CNT_W.
module pipe_perf_cnt #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc) begin
            if (!SATURATE || (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer
// behind a registered in_ready, synchronous flush and perf counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt_xfer,
    output logic [CNT_W-1:0]  cnt_stall
);

    stage_state_t      state;
    stage_state_t      next_state;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              acc;
    logic              drn;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid_in;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_d;
    assign acc       = in_valid & in_ready;
    assign drn       = out_valid & out_ready;

    always_comb begin
        next_state     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (acc) begin
                    next_state   = ST_ONE;
                    load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (acc && drn) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    next_state   = ST_TWO;
                    load_skid_in = 1'b1;
                end else if (drn) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can move the FSM.
                if (drn) begin
                    next_state     = ST_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            main_d   <= '0;
            skid_d   <= '0;
        end else if (flush) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
            if (CLEAR_ON_FLUSH) begin
                main_d <= '0;
                skid_d <= '0;
            end
        end else begin
            state    <= next_state;
            in_ready <= (next_state != ST_TWO);
            if (load_main_in) begin
                main_d <= in_data;
            end else if (load_main_skid) begin
                main_d <= skid_d;
            end
            if (load_skid_in) begin
                skid_d <= in_data;
            end
        end
    end

    // A drain in a flush cycle still counts: downstream really took the entry.
    pipe_perf_cnt #(
        .CNT_W   (CNT_W),
        .SATURATE(1'b0)
    ) u_cnt_xfer (
        .clk  (clk),
        .reset(reset),
        .inc  (drn),
        .cnt  (cnt_xfer)
    );

    pipe_perf_cnt #(
        .CNT_W   (CNT_W),
        .SATURATE(1'b1)
    ) u_cnt_stall (
        .clk  (clk),
        .reset(reset),
        .inc  (out_valid & ~out_ready),
        .cnt  (cnt_stall)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: a default-width instance
// for handshake/flush/reset behaviour and a CNT_W=2 instance for counter limits.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int DW  = DEFAULT_DATA_W;
    localparam int SDW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [31:0]   cnt_xfer;
    logic [31:0]   cnt_stall;

    logic           s_flush;
    logic           s_in_valid;
    logic           s_in_ready;
    logic [SDW-1:0] s_in_data;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [SDW-1:0] s_out_data;
    logic [1:0]     s_cnt_xfer;
    logic [1:0]     s_cnt_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .cnt_xfer (cnt_xfer),
        .cnt_stall(cnt_stall)
    );

    pipe_stage_reg #(
        .DATA_W        (SDW),
        .CLEAR_ON_FLUSH(1'b1),
        .CNT_W         (2)
    ) dut_small (
        .clk      (clk),
        .reset    (reset),
        .flush    (s_flush),
        .in_valid (s_in_valid),
        .in_ready (s_in_ready),
        .in_data  (s_in_data),
        .out_valid(s_out_valid),
        .out_ready(s_out_ready),
        .out_data (s_out_data),
        .cnt_xfer (s_cnt_xfer),
        .cnt_stall(s_cnt_stall)
    );

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_in_data   = '0;
        s_out_ready = 1'b0;

        // Reset then idle
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_in_ready",  128'(in_ready),  128'(1));
        checkOutput("rst_out_data",  128'(out_data),  128'(0));
        checkOutput("rst_cnt_xfer",  128'(cnt_xfer),  128'(0));
        checkOutput("rst_cnt_stall", 128'(cnt_stall), 128'(0));
        applyStimulus();
        checkOutput("idle_out_valid", 128'(out_valid), 128'(0));

        // Streaming with out_ready high
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(8'h11);
        applyStimulus();
        checkOutput("stream_d0",  128'(out_data),  128'(8'h11));
        checkOutput("stream_v0",  128'(out_valid), 128'(1));
        checkOutput("stream_rdy0", 128'(in_ready), 128'(1));
        in_data = DW'(8'h22);
        applyStimulus();
        checkOutput("stream_d1",  128'(out_data),  128'(8'h22));
        checkOutput("stream_rdy1", 128'(in_ready), 128'(1));
        in_data = DW'(8'h33);
        applyStimulus();
        checkOutput("stream_d2",  128'(out_data),  128'(8'h33));
        checkOutput("stream_rdy2", 128'(in_ready), 128'(1));
        in_valid = 1'b0;
        applyStimulus();
        checkOutput("stream_xfer",    128'(cnt_xfer),  128'(3));
        checkOutput("stream_drained", 128'(out_valid), 128'(0));
        checkOutput("stream_stall",   128'(cnt_stall), 128'(0));

        // Stall and skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'hA1);
        applyStimulus();
        checkOutput("stall_d0",  128'(out_data), 128'(8'hA1));
        checkOutput("stall_rdy0", 128'(in_ready), 128'(1));
        in_data = DW'(8'hA2);
        applyStimulus();
        checkOutput("skid_rdy",   128'(in_ready),  128'(0));
        checkOutput("skid_d",     128'(out_data),  128'(8'hA1));
        checkOutput("skid_v",     128'(out_valid), 128'(1));
        in_valid = 1'b0;
        in_data  = DW'(8'hEE);
        applyStimulus();
        checkOutput("skid_hold_d",   128'(out_data), 128'(8'hA1));
        checkOutput("skid_hold_rdy", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        applyStimulus();
        checkOutput("unskid_d",   128'(out_data), 128'(8'hA2));
        checkOutput("unskid_rdy", 128'(in_ready), 128'(1));
        applyStimulus();
        checkOutput("unskid_empty", 128'(out_valid), 128'(0));
        checkOutput("unskid_xfer",  128'(cnt_xfer),  128'(5));
        checkOutput("unskid_stall", 128'(cnt_stall), 128'(2));

        // Flush with two entries held and an incoming entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'hB1);
        applyStimulus();
        in_data = DW'(8'hB2);
        applyStimulus();
        checkOutput("pre_flush_rdy", 128'(in_ready), 128'(0));
        flush   = 1'b1;
        in_data = DW'(8'hFF);
        applyStimulus();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_v",    128'(out_valid), 128'(0));
        checkOutput("flush_rdy",  128'(in_ready),  128'(1));
        checkOutput("flush_d",    128'(out_data),  128'(0));
        checkOutput("flush_stall", 128'(cnt_stall), 128'(4));
        applyStimulus();
        checkOutput("flush_no_ff_v", 128'(out_valid), 128'(0));
        checkOutput("flush_no_ff_d", 128'(out_data),  128'(0));
        checkOutput("flush_xfer",    128'(cnt_xfer),  128'(5));

        // Reset beats flush and a valid input in state ONE
        in_valid = 1'b1;
        in_data  = DW'(8'hC1);
        applyStimulus();
        checkOutput("pre_rst_d", 128'(out_data), 128'(8'hC1));
        reset   = 1'b1;
        flush   = 1'b1;
        in_data = DW'(8'hD1);
        applyStimulus();
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("prio_v",     128'(out_valid), 128'(0));
        checkOutput("prio_rdy",   128'(in_ready),  128'(1));
        checkOutput("prio_d",     128'(out_data),  128'(0));
        checkOutput("prio_stall", 128'(cnt_stall), 128'(0));
        checkOutput("prio_xfer",  128'(cnt_xfer),  128'(0));

        // Counter limits on the CNT_W=2 instance
        s_in_valid = 1'b1;
        s_in_data  = 8'h5A;
        applyStimulus();
        s_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("sat_stall", 128'(s_cnt_stall), 128'(3));
        checkOutput("sat_hold_d", 128'(s_out_data), 128'(8'h5A));
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in_data = 8'(8'h60 + i);
            applyStimulus();
        end
        s_in_valid  = 1'b0;
        s_out_ready = 1'b0;
        checkOutput("wrap_xfer",  128'(s_cnt_xfer),  128'(1));
        checkOutput("wrap_last_d", 128'(s_out_data), 128'(8'h64));
        checkOutput("sat_stall_kept", 128'(s_cnt_stall), 128'(3));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
